// File: rtl/delta_theta_calc.sv
// Converts absolute angle samples (urad) into wrapped per-step increments in [-pi, pi).
// One start/done transaction per sample: IDLE -> CAPTURE -> DIFF -> NORM -> FINISH.
module delta_theta_calc #(
  parameter longint TWO_PI_URAD = 64'sd6283185,
  parameter longint PI_URAD     = 64'sd3141593
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [63:0] theta,
  output logic signed [63:0] delta_theta,
  output logic               done,
  output logic               first,
  output logic               range_err
);

  localparam int unsigned DW = 64;

  localparam logic signed [DW-1:0] TWO_PI   = DW'(TWO_PI_URAD);
  localparam logic signed [DW-1:0] PI       = DW'(PI_URAD);
  localparam logic signed [DW-1:0] NEG_PI   = -PI;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    DIFF    = 3'd2,
    NORM    = 3'd3,
    FINISH  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] cur_q, cur_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic signed [DW-1:0] diff_q, diff_d;
  logic                 primed_q, primed_d;
  logic                 oor_q, oor_d;
  logic signed [DW-1:0] delta_q, delta_d;
  logic                 first_q, first_d;
  logic                 range_err_q, range_err_d;
  logic                 done_q;

  // Single wrap correction; in-range inputs keep diff within (-2pi, 2pi).
  logic signed [DW-1:0] wrapped_c;
  always_comb begin
    wrapped_c = diff_q;
    if (diff_q >= PI) begin
      wrapped_c = diff_q - TWO_PI;
    end else if (diff_q < NEG_PI) begin
      wrapped_c = diff_q + TWO_PI;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    diff_d      = diff_q;
    primed_d    = primed_q;
    oor_d       = oor_q;
    delta_d     = delta_q;
    first_d     = first_q;
    range_err_d = range_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cur_d   = theta;
        oor_d   = (theta < DW'(0)) || (theta >= TWO_PI);
        state_d = DIFF;
      end
      DIFF: begin
        diff_d  = cur_q - prev_q;
        state_d = NORM;
      end
      NORM: begin
        if (oor_q) begin
          // Rejected sample leaves the reference angle untouched.
          delta_d     = '0;
          range_err_d = 1'b1;
          first_d     = 1'b0;
        end else if (!primed_q) begin
          delta_d     = '0;
          first_d     = 1'b1;
          range_err_d = 1'b0;
          prev_d      = cur_q;
          primed_d    = 1'b1;
        end else begin
          delta_d     = wrapped_c;
          first_d     = 1'b0;
          range_err_d = 1'b0;
          prev_d      = cur_q;
        end
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      prev_q      <= '0;
      diff_q      <= '0;
      primed_q    <= 1'b0;
      oor_q       <= 1'b0;
      delta_q     <= '0;
      first_q     <= 1'b0;
      range_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      diff_q      <= diff_d;
      primed_q    <= primed_d;
      oor_q       <= oor_d;
      delta_q     <= delta_d;
      first_q     <= first_d;
      range_err_q <= range_err_d;
      // Registered copy of "state is FINISH".
      done_q      <= (state_d == FINISH);
    end
  end

  assign delta_theta = delta_q;
  assign done        = done_q;
  assign first       = first_q;
  assign range_err   = range_err_q;

endmodule
